imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port instruction memory (32-bit words, 1-cycle registered read, byte write enables) between two requesters.
- Port A is the core instruction fetch and is read-only. Port B is the loader/debug port and can read or write.
- Round-robin arbitration with an optional bounded bus lock for port B bursts (program load). Drives the memory's enable, byte-write-enable, address and write-data inputs, and routes read data back to the requester that issued the read.

Parameters:
AW, 12, memory word-address width (depth 2**AW words); requester addresses are byte addresses of AW+2 bits
MAX_LOCK, 16, maximum consecutive B grants under lock while A is requesting, before A is forced one grant

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
a_req_i  input  1  fetch read request
a_addr_i  input  AW+2  fetch byte address
a_gnt_o  output  1  fetch request accepted this cycle
a_rvalid_o  output  1  fetch read data valid
a_rdata_o  output  32  fetch read data
b_req_i  input  1  loader request
b_we_i  input  4  loader byte write strobes; 0 = read
b_addr_i  input  AW+2  loader byte address
b_wdata_i  input  32  loader write data
b_lock_i  input  1  loader requests to keep the memory across consecutive cycles
b_gnt_o  output  1  loader request accepted this cycle
b_rvalid_o  output  1  loader read data valid (reads only)
b_rdata_o  output  32  loader read data
mem_en_o  output  1  memory enable
mem_we_o  output  4  memory byte write enables
mem_adr_o  output  AW  memory word address
mem_wdata_o  output  32  memory write data
mem_rdata_i  input  32  memory read data, valid one cycle after enable

Behaviour:
- Grant is combinational from the requests and registered state. At most one grant per cycle. A request stays asserted with stable fields until it is granted.
- Address mapping: mem_adr_o = granted_addr[AW+1:2]. Byte-address bits [1:0] are ignored.
- On an A grant: mem_en_o=1, mem_we_o=0.
- On a B grant: mem_en_o=1, mem_we_o=b_we_i, mem_wdata_o=b_wdata_i.
- With no grant: mem_en_o=0, mem_we_o=0. mem_adr_o and mem_wdata_o are don't-care but are held at the A path to limit toggling.
- Registered state:
  - last_b: 1 when the most recent grant went to B.
  - pend: 2-bit one-hot {B,A} naming which port is owed read data next cycle.
  - lock_cnt: count of consecutive B grants under lock, clog2(MAX_LOCK+1) bits.
- Arbitration when both ports request:
  - No active lock: grant the port not granted last (round-robin on last_b).
  - Lock active (b_lock_i=1, last_b=1, lock_cnt<MAX_LOCK): grant B.
  - lock_cnt==MAX_LOCK: grant A once, clear lock_cnt.
- lock_cnt updates:
  - Increments on a B grant while b_lock_i=1 and a_req_i=1.
  - Clears on any A grant or when b_lock_i=0.
  - Saturates at MAX_LOCK.
- A single requester is always granted, so there are no idle bubbles.
- Read return:
  - A read granted in cycle N gives a_rvalid_o=1 (or b_rvalid_o=1) in cycle N+1, with a_rdata_o/b_rdata_o = mem_rdata_i.
  - B writes produce no rvalid.
  - rdata outputs not flagged valid are don't-care.
  - Back-to-back grants give back-to-back rvalids. Throughput is 1 access per cycle.
- Same-address read then write on consecutive cycles: the read returns pre-write data. The memory reads the old word in the write cycle.
- Reset (asynchronous, any time):
  - last_b=1, so A wins the first conflict.
  - pend=0, lock_cnt=0.
  - All gnt/rvalid outputs 0, mem_en_o=0, mem_we_o=0.
  - A read in flight at reset assertion is dropped; no rvalid is issued after reset is released.
- Simultaneous request and rvalid on the same port is legal. The new grant and the old data return are independent.

Test Plan:
- Reset, then a_req_i=1 at a_addr_i=0x10 → a_gnt_o=1, mem_en_o=1, mem_adr_o=0x004, mem_we_o=0. Next cycle a_rvalid_o=1 with a_rdata_o = the preloaded word.
- Both request continuously, no lock → grants alternate A,B,A,B starting with A. Each rvalid lands on the matching port one cycle after its grant.
- B write b_we_i=4'b0011, addr 0x20, data 0xDEADBEEF over preload 0x11223344, then A reads 0x20 → a_rdata_o=0x1122BEEF. b_rvalid_o stays 0 for the write.
- b_lock_i=1 with both requesting, MAX_LOCK=16 → 16 consecutive B grants, 1 A grant, then B resumes. Drop the lock → round-robin returns.
- Assert rst_n=0 in the cycle after an A grant → no a_rvalid_o. All outputs are 0 during reset. The first conflict after reset goes to A.
- B read then B write to the same word on consecutive cycles → b_rvalid_o returns the old value. A later read returns the written value.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Requester and memory-side signals of the instruction-memory arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface imem_arbiter_if #(
  parameter int AW = 12
);
  logic          a_req_i;
  logic [AW+1:0] a_addr_i;
  logic          a_gnt_o;
  logic          a_rvalid_o;
  logic [31:0]   a_rdata_o;

  logic          b_req_i;
  logic [3:0]    b_we_i;
  logic [AW+1:0] b_addr_i;
  logic [31:0]   b_wdata_i;
  logic          b_lock_i;
  logic          b_gnt_o;
  logic          b_rvalid_o;
  logic [31:0]   b_rdata_o;

  logic          mem_en_o;
  logic [3:0]    mem_we_o;
  logic [AW-1:0] mem_adr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  modport slave (
    input  a_req_i, a_addr_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_lock_i,
    output b_gnt_o, b_rvalid_o, b_rdata_o,
    output mem_en_o, mem_we_o, mem_adr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output a_req_i, a_addr_i,
    input  a_gnt_o, a_rvalid_o, a_rdata_o,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_lock_i,
    input  b_gnt_o, b_rvalid_o, b_rdata_o,
    input  mem_en_o, mem_we_o, mem_adr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory between
// the fetch port (A, read-only) and the loader port (B) with bounded lock.
//
// state      | meaning
// last_b     | 1: most recent grant went to B (A wins the next conflict)
// pend[1:0]  | one-hot {B,A}: port owed read data this cycle
// lock_cnt   | consecutive locked B grants while A is waiting
module imem_arbiter #(
  parameter int AW       = 12,
  parameter int MAX_LOCK = 16
) (
  input logic           clk,
  input logic           rst_n,
  imem_arbiter_if.slave bus
);
  localparam int             LW       = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0]  LOCK_MAX = LW'(MAX_LOCK);

  logic          last_b_q, last_b_d;
  logic [1:0]    pend_q, pend_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          gnt_a, gnt_b;
  logic          lock_active;
  logic          unused_addr_lsbs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q   <= 1'b1;
      pend_q     <= 2'b00;
      lock_cnt_q <= '0;
    end else begin
      last_b_q   <= last_b_d;
      pend_q     <= pend_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    lock_active = bus.b_lock_i && last_b_q && (lock_cnt_q < LOCK_MAX);
    // Grants are gated by reset so every output is quiet while rst_n is low.
    if (rst_n) begin
      if (bus.a_req_i && bus.b_req_i) begin
        if (lock_cnt_q == LOCK_MAX) gnt_a = 1'b1;
        else if (lock_active)       gnt_b = 1'b1;
        else if (last_b_q)          gnt_a = 1'b1;
        else                        gnt_b = 1'b1;
      end else begin
        gnt_a = bus.a_req_i;
        gnt_b = bus.b_req_i;
      end
    end

    last_b_d = gnt_b ? 1'b1 : (gnt_a ? 1'b0 : last_b_q);
    pend_d   = {gnt_b && (bus.b_we_i == 4'b0000), gnt_a};

    lock_cnt_d = lock_cnt_q;
    if (gnt_a || !bus.b_lock_i)
      lock_cnt_d = '0;
    else if (gnt_b && bus.a_req_i && (lock_cnt_q < LOCK_MAX))
      lock_cnt_d = lock_cnt_q + LW'(1);
  end

  always_comb begin
    bus.a_gnt_o     = gnt_a;
    bus.b_gnt_o     = gnt_b;
    bus.mem_en_o    = gnt_a | gnt_b;
    bus.mem_we_o    = gnt_b ? bus.b_we_i : 4'b0000;
    bus.mem_adr_o   = gnt_b ? bus.b_addr_i[AW+1:2] : bus.a_addr_i[AW+1:2];
    bus.mem_wdata_o = gnt_b ? bus.b_wdata_i : 32'h0;
    bus.a_rvalid_o  = pend_q[0];
    bus.b_rvalid_o  = pend_q[1];
    bus.a_rdata_o   = bus.mem_rdata_i;
    bus.b_rdata_o   = bus.mem_rdata_i;
  end

  assign unused_addr_lsbs = ^{bus.a_addr_i[1:0], bus.b_addr_i[1:0]};
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural read-before-write memory.
module tb_imem_arbiter;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  imem_arbiter_if #(.AW(AW)) bus ();

  imem_arbiter #(.AW(AW), .MAX_LOCK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      bus.mem_rdata_i <= mem[bus.mem_adr_o];
      for (int i = 0; i < 4; i++)
        if (bus.mem_we_o[i]) mem[bus.mem_adr_o][8*i +: 8] <= bus.mem_wdata_o[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[4]  = 32'hCAFE0004;
    mem[8]  = 32'h11223344;
    mem[9]  = 32'h99990009;
    mem[12] = 32'h55AA55AA;

    bus.mem_rdata_i = 32'h0;
    bus.a_req_i = 1'b1; bus.a_addr_i = 14'h010;
    bus.b_req_i = 1'b1; bus.b_we_i = 4'h0; bus.b_addr_i = 14'h024;
    bus.b_wdata_i = 32'h0; bus.b_lock_i = 1'b0;

    // reset with both requesting: everything quiet
    @(negedge clk);
    chk("rst_a_gnt", bus.a_gnt_o, 0);
    chk("rst_b_gnt", bus.b_gnt_o, 0);
    chk("rst_en", bus.mem_en_o, 0);
    chk("rst_we", bus.mem_we_o, 0);
    chk("rst_a_rvalid", bus.a_rvalid_o, 0);
    chk("rst_b_rvalid", bus.b_rvalid_o, 0);
    cyc();

    // single A fetch
    rst_n = 1'b1; bus.b_req_i = 1'b0;
    @(negedge clk);
    chk("t1_a_gnt", bus.a_gnt_o, 1);
    chk("t1_en", bus.mem_en_o, 1);
    chk("t1_adr", bus.mem_adr_o, 12'h004);
    chk("t1_we", bus.mem_we_o, 0);
    cyc();
    bus.a_req_i = 1'b0;
    @(negedge clk);
    chk("t1_a_rvalid", bus.a_rvalid_o, 1);
    chk("t1_a_rdata", bus.a_rdata_o, 32'hCAFE0004);
    chk("t1_idle_en", bus.mem_en_o, 0);
    cyc();

    // lone B read makes B the last grantee, then both contend: A,B,A,B
    bus.b_req_i = 1'b1; bus.b_we_i = 4'h0; bus.b_addr_i = 14'h024;
    @(negedge clk);
    chk("t2_b_gnt", bus.b_gnt_o, 1);
    chk("t2_adr", bus.mem_adr_o, 12'h009);
    cyc();
    bus.a_req_i = 1'b1; bus.a_addr_i = 14'h010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_rr_a_gnt", bus.a_gnt_o, (k % 2 == 0));
      chk("t2_rr_b_gnt", bus.b_gnt_o, (k % 2 == 1));
      chk("t2_rr_a_rvalid", bus.a_rvalid_o, (k % 2 == 1));
      chk("t2_rr_b_rvalid", bus.b_rvalid_o, (k % 2 == 0));
      if (k % 2 == 0) chk("t2_rr_b_rdata", bus.b_rdata_o, 32'h99990009);
      else            chk("t2_rr_a_rdata", bus.a_rdata_o, 32'hCAFE0004);
      cyc();
    end
    bus.a_req_i = 1'b0; bus.b_req_i = 1'b0;
    @(negedge clk);
    chk("t2_last_b_rvalid", bus.b_rvalid_o, 1);
    chk("t2_last_a_rvalid", bus.a_rvalid_o, 0);
    cyc();

    // partial B write, then A reads the merged word
    bus.b_req_i = 1'b1; bus.b_we_i = 4'b0011; bus.b_addr_i = 14'h020;
    bus.b_wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t3_b_gnt", bus.b_gnt_o, 1);
    chk("t3_we", bus.mem_we_o, 4'b0011);
    chk("t3_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
    chk("t3_adr", bus.mem_adr_o, 12'h008);
    cyc();
    bus.b_req_i = 1'b0; bus.b_we_i = 4'h0;
    bus.a_req_i = 1'b1; bus.a_addr_i = 14'h020;
    @(negedge clk);
    chk("t3_wr_no_rvalid", bus.b_rvalid_o, 0);
    chk("t3_a_gnt", bus.a_gnt_o, 1);
    cyc();
    bus.a_req_i = 1'b0;
    @(negedge clk);
    chk("t3_a_rvalid", bus.a_rvalid_o, 1);
    chk("t3_a_rdata", bus.a_rdata_o, 32'h1122BEEF);
    cyc();

    // locked B burst: 16 B grants, one forced A, B resumes
    bus.a_req_i = 1'b1; bus.a_addr_i = 14'h010;
    bus.b_req_i = 1'b1; bus.b_we_i = 4'h0; bus.b_addr_i = 14'h024;
    bus.b_lock_i = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("t4_lock_b_gnt", bus.b_gnt_o, (k != 16));
      chk("t4_lock_a_gnt", bus.a_gnt_o, (k == 16));
      cyc();
    end
    bus.b_lock_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_unlock_a_gnt", bus.a_gnt_o, (k % 2 == 0));
      chk("t4_unlock_b_gnt", bus.b_gnt_o, (k % 2 == 1));
      cyc();
    end
    bus.a_req_i = 1'b0; bus.b_req_i = 1'b0;
    cyc();

    // reset right after an A grant drops the return
    bus.a_req_i = 1'b1; bus.a_addr_i = 14'h010;
    @(negedge clk);
    chk("t5_a_gnt", bus.a_gnt_o, 1);
    cyc();
    rst_n = 1'b0; bus.b_req_i = 1'b1;
    @(negedge clk);
    chk("t5_rst_a_rvalid", bus.a_rvalid_o, 0);
    chk("t5_rst_b_rvalid", bus.b_rvalid_o, 0);
    chk("t5_rst_a_gnt", bus.a_gnt_o, 0);
    chk("t5_rst_b_gnt", bus.b_gnt_o, 0);
    chk("t5_rst_en", bus.mem_en_o, 0);
    chk("t5_rst_we", bus.mem_we_o, 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_conflict_a", bus.a_gnt_o, 1);
    chk("t5_first_conflict_b", bus.b_gnt_o, 0);
    chk("t5_no_stale_rvalid", bus.a_rvalid_o, 0);
    cyc();
    @(negedge clk);
    chk("t5_second_conflict_b", bus.b_gnt_o, 1);
    cyc();
    bus.a_req_i = 1'b0; bus.b_req_i = 1'b0;
    cyc();

    // B read then B write to the same word: read sees the old value
    bus.b_req_i = 1'b1; bus.b_we_i = 4'h0; bus.b_addr_i = 14'h030;
    @(negedge clk);
    chk("t6_rd_gnt", bus.b_gnt_o, 1);
    cyc();
    bus.b_we_i = 4'hF; bus.b_wdata_i = 32'h0BADF00D;
    @(negedge clk);
    chk("t6_wr_gnt", bus.b_gnt_o, 1);
    chk("t6_old_rvalid", bus.b_rvalid_o, 1);
    chk("t6_old_rdata", bus.b_rdata_o, 32'h55AA55AA);
    cyc();
    bus.b_we_i = 4'h0;
    @(negedge clk);
    chk("t6_wr_no_rvalid", bus.b_rvalid_o, 0);
    cyc();
    bus.b_req_i = 1'b0;
    @(negedge clk);
    chk("t6_new_rvalid", bus.b_rvalid_o, 1);
    chk("t6_new_rdata", bus.b_rdata_o, 32'h0BADF00D);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
